// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard control unit
package hazard_pkg;
   typedef enum logic {IDLE, BUSY} md_state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/muldiv_busy_tracker.sv
// muldiv_busy_tracker: tracks HI/LO occupancy after a mult/div launches from EX
module muldiv_busy_tracker
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic Ex_MulDiv,
   output logic md_busy
);
   localparam int CW = $clog2(MD_LATENCY + 1);
   md_state_t state;
   logic [CW-1:0] md_cnt;
   // A launch seen while already busy is ignored: no reload, stay BUSY
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         md_cnt <= '0;
      end else if (state == IDLE) begin
         if (Ex_MulDiv) begin
            state  <= BUSY;
            md_cnt <= CW'(MD_LATENCY - 1);
         end
      end else if (md_cnt == CW'(1)) begin
         state  <= IDLE;
         md_cnt <= '0;
      end else begin
         md_cnt <= md_cnt - CW'(1);
      end
   end
   assign md_busy = state == BUSY;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use, HI/LO and branch-squash pipeline control with perf counters
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 8,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_UsesHiLo,
   input  logic             ID_MulDiv,
   input  logic             Ex_MemRead,
   input  logic [4:0]       Ex_rt,
   input  logic             Ex_MulDiv,
   input  logic             Ex_BranchTaken,
   output logic             PC_hold,
   output logic             IFID_hold,
   output logic             IFID_flush,
   output logic             stall,
   output logic             flushB,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   logic busy_q, lu, hl;
   muldiv_busy_tracker #(.MD_LATENCY(MD_LATENCY)) u_md (
      .clk      (clk),
      .reset    (reset),
      .Ex_MulDiv(Ex_MulDiv),
      .md_busy  (busy_q)
   );
   assign lu = Ex_MemRead && Ex_rt != REG_ZERO &&
               ((ID_UsesRs && ID_rs == Ex_rt) || (ID_UsesRt && ID_rt == Ex_rt));
   assign hl = (busy_q || Ex_MulDiv) && (ID_UsesHiLo || ID_MulDiv);
   // A squashed ID instruction need not be stalled, so the branch wins
   assign stall      = !reset && (lu || hl) && !Ex_BranchTaken;
   assign flushB     = !reset && Ex_BranchTaken;
   assign IFID_flush = flushB;
   assign PC_hold    = stall;
   assign IFID_hold  = stall;
   assign md_busy    = !reset && busy_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flushB && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: table vectors, corner sequences and random run against a reference model
module tb_hazard_ctrl_unit;
   localparam int L = 8;
   logic clk = 0;
   logic reset;
   logic [4:0] ID_rs, ID_rt, Ex_rt;
   logic ID_UsesRs, ID_UsesRt, ID_UsesHiLo, ID_MulDiv, Ex_MemRead, Ex_MulDiv, Ex_BranchTaken;
   logic PC_hold, IFID_hold, IFID_flush, stall, flushB, md_busy;
   logic [31:0] stall_cnt, flush_cnt;
   logic s_pc_hold, s_ifid_hold, s_ifid_flush, s_stall, s_flushb, s_md_busy;
   logic [2:0] s_stall_cnt, s_flush_cnt;
   int total = 0, bad = 0;
   int rem = 0;
   longint sc = 0, fc = 0, ss = 0, fs = 0;
   logic obs_stall, obs_busy;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.MD_LATENCY(L), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_UsesHiLo(ID_UsesHiLo),
      .ID_MulDiv(ID_MulDiv), .Ex_MemRead(Ex_MemRead), .Ex_rt(Ex_rt),
      .Ex_MulDiv(Ex_MulDiv), .Ex_BranchTaken(Ex_BranchTaken),
      .PC_hold(PC_hold), .IFID_hold(IFID_hold), .IFID_flush(IFID_flush),
      .stall(stall), .flushB(flushB), .md_busy(md_busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter copy makes saturation reachable in a short run
   hazard_ctrl_unit #(.MD_LATENCY(L), .CNT_W(3)) dut_s (
      .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_UsesHiLo(ID_UsesHiLo),
      .ID_MulDiv(ID_MulDiv), .Ex_MemRead(Ex_MemRead), .Ex_rt(Ex_rt),
      .Ex_MulDiv(Ex_MulDiv), .Ex_BranchTaken(Ex_BranchTaken),
      .PC_hold(s_pc_hold), .IFID_hold(s_ifid_hold), .IFID_flush(s_ifid_flush),
      .stall(s_stall), .flushB(s_flushb), .md_busy(s_md_busy),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   typedef struct {
      logic [4:0] rs, rt;
      logic urs, urt, hilo, mdid, mr;
      logic [4:0] ert;
      logic bt, es, ef;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs, rt, input logic urs, urt, hilo, mdid, mr,
                        input logic [4:0] ert, input logic emd, bt);
      ID_rs = rs; ID_rt = rt; ID_UsesRs = urs; ID_UsesRt = urt; ID_UsesHiLo = hilo;
      ID_MulDiv = mdid; Ex_MemRead = mr; Ex_rt = ert; Ex_MulDiv = emd; Ex_BranchTaken = bt;
   endtask

   task automatic cycle(input string tag);
      logic lu, hl, busy, st, fl;
      @(negedge clk);
      assert (reset || rem == 0 || !Ex_MulDiv) else $error("launch while busy");
      busy = !reset && rem > 0;
      lu = Ex_MemRead && Ex_rt != 0 &&
           ((ID_UsesRs && ID_rs == Ex_rt) || (ID_UsesRt && ID_rt == Ex_rt));
      hl = (busy || Ex_MulDiv) && (ID_UsesHiLo || ID_MulDiv);
      st = !reset && (lu || hl) && !Ex_BranchTaken;
      fl = !reset && Ex_BranchTaken;
      obs_stall = stall;
      obs_busy = md_busy;
      check({tag, ".stall"}, stall, st);
      check({tag, ".pc_hold"}, PC_hold, st);
      check({tag, ".ifid_hold"}, IFID_hold, st);
      check({tag, ".flushB"}, flushB, fl);
      check({tag, ".ifid_flush"}, IFID_flush, fl);
      check({tag, ".md_busy"}, md_busy, busy);
      check({tag, ".stall_cnt"}, stall_cnt, sc);
      check({tag, ".flush_cnt"}, flush_cnt, fc);
      check({tag, ".s_stall_cnt"}, s_stall_cnt, ss);
      check({tag, ".s_flush_cnt"}, s_flush_cnt, fs);
      @(posedge clk);
      if (reset) begin
         rem = 0; sc = 0; fc = 0; ss = 0; fs = 0;
      end else begin
         if (st) begin
            sc = (sc < 64'hFFFF_FFFF) ? sc + 1 : sc;
            ss = (ss < 7) ? ss + 1 : ss;
         end
         if (fl) begin
            fc = (fc < 64'hFFFF_FFFF) ? fc + 1 : fc;
            fs = (fs < 7) ? fs + 1 : fs;
         end
         if (rem > 0) rem--;
         else if (Ex_MulDiv) rem = L - 1;
      end
      #1;
   endtask

   initial begin
      int nst, nbusy;
      tbl[0] = '{5, 0, 1, 0, 0, 0, 1, 5, 0, 1, 0};
      tbl[1] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
      tbl[2] = '{0, 5, 0, 0, 0, 0, 1, 5, 0, 0, 0};
      tbl[3] = '{0, 5, 0, 1, 0, 0, 1, 5, 0, 1, 0};
      tbl[4] = '{5, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0};
      tbl[5] = '{5, 0, 1, 0, 0, 0, 1, 5, 1, 0, 1};
      tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
      tbl[7] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};

      reset = 1;
      drive(5, 5, 1, 1, 1, 1, 1, 5, 1, 1);
      @(negedge clk);
      check("rst.stall", stall, 0);
      check("rst.flushB", flushB, 0);
      check("rst.pc_hold", PC_hold, 0);
      check("rst.ifid_flush", IFID_flush, 0);
      @(posedge clk); #1;
      cycle("rst");
      reset = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("idle");

      foreach (tbl[i]) begin
         drive(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].hilo, tbl[i].mdid,
               tbl[i].mr, tbl[i].ert, 0, tbl[i].bt);
         #1;
         check($sformatf("vec%0d.stall", i), stall, tbl[i].es);
         check($sformatf("vec%0d.flushB", i), flushB, tbl[i].ef);
         cycle($sformatf("vec%0d", i));
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("after_vec");
      check("vec.stall_cnt", stall_cnt, 2);
      check("vec.flush_cnt", flush_cnt, 2);

      nst = 0; nbusy = 0;
      drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      cycle("md_launch");
      nst += obs_stall; nbusy += obs_busy;
      Ex_MulDiv = 0;
      for (int k = 0; k < 12; k++) begin
         cycle("md_hold");
         nst += obs_stall; nbusy += obs_busy;
      end
      check("md.stall_cycles", nst, L);
      check("md.busy_cycles", nbusy, L - 1);

      drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      cycle("rst_launch");
      Ex_MulDiv = 0;
      repeat (3) cycle("rst_busy");
      reset = 1;
      cycle("rst_mid");
      reset = 0;
      cycle("rst_after");
      check("rst_after.md_busy", obs_busy, 0);
      check("rst_after.stall", obs_stall, 0);
      check("rst_after.stall_cnt", stall_cnt, 0);

      for (int k = 0; k < 400; k++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
               5'($urandom_range(0, 3)), (rem == 0 && $urandom_range(0, 9) == 0),
               ($urandom_range(0, 5) == 0));
         cycle("rnd");
      end
      reset = 0;

      drive(5, 0, 1, 0, 0, 0, 1, 5, 0, 0);
      repeat (10) cycle("sat_stall");
      check("sat.s_stall_cnt", s_stall_cnt, 7);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (10) cycle("sat_flush");
      check("sat.s_flush_cnt", s_flush_cnt, 7);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
